score_sheet_controller: RTL and testbench
=========================================

SCORE_SHEET_CONTROLLER -- requirements
Module: score_sheet_controller

Interface
REQ-001 SHALL have parameter NUM_CAT, default 12, number of scoring categories (indices 0..NUM_CAT-1).
REQ-002 SHALL have parameter BONUS_THRESH, default 63, minimum upper-section sum (categories 0..5) that earns the bonus.
REQ-003 SHALL have parameter BONUS_VAL, default 35, bonus points added to the total.
REQ-004 SHALL have port clk  input  1  system clock; all state changes on the rising edge.
REQ-005 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port sweep_start  input  1  one-cycle pulse requesting a best-category sweep.
REQ-007 SHALL have port commit_req  input  1  one-cycle pulse requesting that the score of commit_cat be recorded.
REQ-008 SHALL have port commit_cat  input  4  category to commit, sampled with commit_req.
REQ-009 SHALL have port player  input  1  0=P1, 1=P2, sampled with sweep_start or commit_req.
REQ-010 SHALL have port calc_score  input  8  combinational score for cat_sel, from the score calculator.
REQ-011 SHALL have port cat_sel  output  4  registered category select driven to the score calculator.
REQ-012 SHALL have port busy  output  1  high in any non-IDLE state.
REQ-013 SHALL have port sweep_done  output  1  one-cycle pulse; best_cat/best_score valid.
REQ-014 SHALL have port best_cat  output  4  highest-scoring unused category; 4'hF when none.
REQ-015 SHALL have port best_score  output  8  score of best_cat; 0 when none.
REQ-016 SHALL have port commit_ack  output  1  one-cycle pulse; commit accepted.
REQ-017 SHALL have port commit_err  output  1  one-cycle pulse; commit rejected.
REQ-018 SHALL have ports p1_total, p2_total  output  9 each  running totals including bonus.
REQ-019 SHALL have port game_over  output  1  high while both players have used all NUM_CAT categories.

Function
REQ-020 SHALL implement FSM states IDLE, SWEEP, COMMIT, REPORT; new requests are accepted in IDLE only, and requests arriving in any other state are dropped without response.
REQ-021 SHALL give commit_req priority over sweep_start when both are high in IDLE; the sweep is dropped.
REQ-022 Sweep: on sweep_start at edge N, SHALL latch player, then drive cat_sel=k during cycle N+1+k for k=0..NUM_CAT-1.
REQ-023 Sweep: SHALL sample calc_score at the end of each SWEEP cycle.
REQ-024 Sweep: SHALL enter REPORT with sweep_done=1 in cycle N+NUM_CAT+1, then return to IDLE.
REQ-025 Sweep: SHALL consider only categories unused by the latched player; a zero score is eligible; ties resolve to the lowest index.
REQ-026 Sweep: best_cat/best_score SHALL hold until the next sweep_done.
REQ-027 Commit: on commit_req at edge N, SHALL latch player and commit_cat and enter COMMIT with cat_sel=commit_cat during cycle N+1.
REQ-028 Commit: at the end of cycle N+1, SHALL take the error path if commit_cat>=NUM_CAT or the category is already used by that player.
REQ-029 Commit error path: no state change; commit_err=1 in cycle N+2.
REQ-030 Commit success path: store calc_score in that player's score register and set the used bit; commit_ack=1 in cycle N+2.
REQ-031 Commit: new totals SHALL be visible in cycle N+2.
REQ-032 Commit: after the commit the FSM SHALL return to IDLE through REPORT, and sweep_done SHALL NOT assert.
REQ-033 Total SHALL equal upper_sum + lower_sum + (upper_sum>=BONUS_THRESH ? BONUS_VAL : 0).
REQ-034 Total width SHALL be 9 bits; maximum 345, no saturation needed.
REQ-035 Total SHALL be computed combinationally from the score registers.
REQ-036 calc_score SHALL be treated as valid only while cat_sel is stable for the whole cycle; dice stability during a sweep is the requester's responsibility.
REQ-037 commit_ack, commit_err and sweep_done SHALL be mutually exclusive and each one cycle wide.

Reset
REQ-038 On reset_n=0, SHALL asynchronously set state IDLE, cat_sel=0, all score registers and used bits 0, best_cat=4'hF, best_score=0, and all pulses, busy and game_over to 0.
REQ-039 On reset_n=0 mid-sweep or mid-commit, SHALL abort the operation; no pulse is issued and no partial write occurs.
REQ-040 After reset_n returns to 1, SHALL accept a request on the first rising edge.

Verification
REQ-041 Dice all 5, sweep_start with player=0 -> busy for 13 cycles; cat_sel steps 0..11; sweep_done with best_cat=11, best_score=50.
REQ-042 Same dice, commit_req cat=11 P1 -> commit_ack 2 cycles later; p1_total=50; repeat commit cat=11 -> commit_err, p1_total stays 50.
REQ-043 P1 commits upper categories totaling exactly 63 (e.g. 3,6,9,12,15,18 via three-of-each dice) -> p1_total=98; totaling 62 -> 62.
REQ-044 Dice 1,2,3,4,5, sweep -> best_cat=10, best_score=40; after committing 10, sweep -> best_cat=9, best_score=30.
REQ-045 commit_cat=12 -> commit_err, no used bit set; commit_req and sweep_start in the same cycle -> only commit_ack and no sweep_done; reset_n low at cycle 5 of a sweep -> no sweep_done and best_cat=4'hF.
REQ-046 Both players commit all 12 categories -> game_over=1; sweep -> best_cat=4'hF, best_score=0.

Source files
------------

// File: rtl/score_sheet_controller.sv
`default_nettype none
// ============================================================================
// score_sheet_controller
// Dice-game score sheet: best-unused-category sweep, score commit, totals.
// Rev 1.0
// ============================================================================
module score_sheet_controller #(
  parameter int NUM_CAT      = 12,
  parameter int BONUS_THRESH = 63,
  parameter int BONUS_VAL    = 35
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       sweep_start,
  input  logic       commit_req,
  input  logic [3:0] commit_cat,
  input  logic       player,
  input  logic [7:0] calc_score,
  output logic [3:0] cat_sel,
  output logic       busy,
  output logic       sweep_done,
  output logic [3:0] best_cat,
  output logic [7:0] best_score,
  output logic       commit_ack,
  output logic       commit_err,
  output logic [8:0] p1_total,
  output logic [8:0] p2_total,
  output logic       game_over
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SWEEP  = 2'd1;
  localparam logic [1:0] S_COMMIT = 2'd2;
  localparam logic [1:0] S_REPORT = 2'd3;

  localparam logic [1:0] K_NONE = 2'd0;
  localparam logic [1:0] K_DONE = 2'd1;
  localparam logic [1:0] K_ACK  = 2'd2;
  localparam logic [1:0] K_ERR  = 2'd3;

  localparam logic [3:0] C_LAST_CAT = 4'(NUM_CAT - 1);
  localparam logic [3:0] C_NO_CAT   = 4'hF;

  logic [1:0]         r_state;
  logic [1:0]         w_next_state;
  logic [1:0]         r_kind;
  logic               r_player;
  logic [7:0]         r_score [2][NUM_CAT];
  logic [NUM_CAT-1:0] r_used  [2];
  logic               r_cand_valid;
  logic [3:0]         r_cand_cat;
  logic [7:0]         r_cand_score;

  logic [NUM_CAT-1:0] w_cat_hit;
  logic               w_cat_valid;
  logic               w_cat_used;
  logic               w_take;
  logic [3:0]         w_next_cat;
  logic [7:0]         w_next_score;
  logic [8:0]         w_upper [2];
  logic [8:0]         w_lower [2];
  logic [8:0]         w_total [2];

  // One-hot decode of cat_sel; all-zero when cat_sel is out of range.
  always_comb begin
    w_cat_hit = '0;
    for (int i = 0; i < NUM_CAT; i++) begin
      w_cat_hit[i] = (cat_sel == 4'(i));
    end
  end

  assign w_cat_valid  = |w_cat_hit;
  assign w_cat_used   = |(w_cat_hit & r_used[r_player]);
  // Strict greater-than keeps the lowest index on ties.
  assign w_take       = w_cat_valid && !w_cat_used &&
                        (!r_cand_valid || (calc_score > r_cand_score));
  assign w_next_cat   = w_take ? cat_sel    : r_cand_cat;
  assign w_next_score = w_take ? calc_score : r_cand_score;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (commit_req) begin
          w_next_state = S_COMMIT;
        end else if (sweep_start) begin
          w_next_state = S_SWEEP;
        end
      end
      S_SWEEP: begin
        if (cat_sel == C_LAST_CAT) begin
          w_next_state = S_REPORT;
        end
      end
      S_COMMIT: w_next_state = S_REPORT;
      S_REPORT: w_next_state = S_IDLE;
      default:  w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    busy       = (r_state != S_IDLE);
    sweep_done = (r_state == S_REPORT) && (r_kind == K_DONE);
    commit_ack = (r_state == S_REPORT) && (r_kind == K_ACK);
    commit_err = (r_state == S_REPORT) && (r_kind == K_ERR);
    game_over  = (&r_used[0]) && (&r_used[1]);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cat_sel      <= '0;
      r_player     <= 1'b0;
      r_kind       <= K_NONE;
      r_cand_valid <= 1'b0;
      r_cand_cat   <= C_NO_CAT;
      r_cand_score <= '0;
      best_cat     <= C_NO_CAT;
      best_score   <= '0;
      r_used[0]    <= '0;
      r_used[1]    <= '0;
      for (int p = 0; p < 2; p++) begin
        for (int i = 0; i < NUM_CAT; i++) begin
          r_score[p][i] <= '0;
        end
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          r_kind <= K_NONE;
          if (commit_req) begin
            r_player <= player;
            cat_sel  <= commit_cat;
          end else if (sweep_start) begin
            r_player     <= player;
            cat_sel      <= '0;
            r_cand_valid <= 1'b0;
            r_cand_cat   <= C_NO_CAT;
            r_cand_score <= '0;
          end
        end
        S_SWEEP: begin
          r_cand_valid <= r_cand_valid | w_take;
          r_cand_cat   <= w_next_cat;
          r_cand_score <= w_next_score;
          if (cat_sel == C_LAST_CAT) begin
            best_cat   <= w_next_cat;
            best_score <= w_next_score;
            r_kind     <= K_DONE;
          end else begin
            cat_sel <= cat_sel + 4'd1;
          end
        end
        S_COMMIT: begin
          if (!w_cat_valid || w_cat_used) begin
            r_kind <= K_ERR;
          end else begin
            r_kind           <= K_ACK;
            r_used[r_player] <= r_used[r_player] | w_cat_hit;
            for (int i = 0; i < NUM_CAT; i++) begin
              if (w_cat_hit[i]) begin
                r_score[r_player][i] <= calc_score;
              end
            end
          end
        end
        default: r_kind <= K_NONE;
      endcase
    end
  end

  // Categories 0..5 form the upper section that qualifies for the bonus.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      w_upper[p] = '0;
      w_lower[p] = '0;
      for (int i = 0; i < NUM_CAT; i++) begin
        if (i < 6) begin
          w_upper[p] = w_upper[p] + 9'(r_score[p][i]);
        end else begin
          w_lower[p] = w_lower[p] + 9'(r_score[p][i]);
        end
      end
      w_total[p] = w_upper[p] + w_lower[p] +
                   ((w_upper[p] >= 9'(BONUS_THRESH)) ? 9'(BONUS_VAL) : 9'd0);
    end
  end

  assign p1_total = w_total[0];
  assign p2_total = w_total[1];

endmodule
`default_nettype wire

// File: tb/tb_score_sheet_controller.sv
`default_nettype none
// tb_score_sheet_controller: directed sweep/commit/reset vectors with
// hand-computed expectations; calc_score comes from a per-phase score table.
module tb_score_sheet_controller;

  logic       clk         = 1'b0;
  logic       reset_n     = 1'b0;
  logic       sweep_start = 1'b0;
  logic       commit_req  = 1'b0;
  logic [3:0] commit_cat  = 4'd0;
  logic       player      = 1'b0;
  logic [7:0] calc_score;
  logic [3:0] cat_sel;
  logic       busy;
  logic       sweep_done;
  logic [3:0] best_cat;
  logic [7:0] best_score;
  logic       commit_ack;
  logic       commit_err;
  logic [8:0] p1_total;
  logic [8:0] p2_total;
  logic       game_over;

  logic [7:0] tbl [16];
  int vectors     = 0;
  int miscompares = 0;

  score_sheet_controller #(
    .NUM_CAT     (12),
    .BONUS_THRESH(63),
    .BONUS_VAL   (35)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .sweep_start(sweep_start),
    .commit_req (commit_req),
    .commit_cat (commit_cat),
    .player     (player),
    .calc_score (calc_score),
    .cat_sel    (cat_sel),
    .busy       (busy),
    .sweep_done (sweep_done),
    .best_cat   (best_cat),
    .best_score (best_score),
    .commit_ack (commit_ack),
    .commit_err (commit_err),
    .p1_total   (p1_total),
    .p2_total   (p2_total),
    .game_over  (game_over)
  );

  always #5 clk = ~clk;

  always_comb calc_score = tbl[cat_sel];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_sweep(input logic p, input logic [3:0] exp_cat,
                          input logic [7:0] exp_score, input bit inject);
    logic stray;
    stray       = 1'b0;
    sweep_start = 1'b1;
    player      = p;
    tick();
    sweep_start = 1'b0;
    for (int k = 0; k < 12; k++) begin
      check("sweep_cat_sel", cat_sel, k);
      if (!busy || sweep_done || commit_ack || commit_err) stray = 1'b1;
      if (inject && k == 3) begin
        commit_req = 1'b1;
        commit_cat = 4'd0;
      end
      tick();
      commit_req = 1'b0;
    end
    check("sweep_report", {busy, sweep_done, commit_ack, commit_err}, 4'b1100);
    check("sweep_stray", stray, 0);
    check("best_cat", best_cat, exp_cat);
    check("best_score", best_score, exp_score);
    tick();
    check("sweep_idle", {busy, sweep_done}, 0);
  endtask

  task automatic do_commit(input logic p, input logic [3:0] cat, input bit with_sweep,
                           input bit exp_ack, input logic [8:0] e1, input logic [8:0] e2);
    commit_req  = 1'b1;
    commit_cat  = cat;
    player      = p;
    sweep_start = with_sweep;
    tick();
    commit_req  = 1'b0;
    sweep_start = 1'b0;
    check("commit_sel", {busy, cat_sel, commit_ack, commit_err, sweep_done}, {1'b1, cat, 3'b000});
    tick();
    check("commit_resp", {busy, commit_ack, commit_err, sweep_done}, {1'b1, exp_ack, !exp_ack, 1'b0});
    check("p1_total", p1_total, e1);
    check("p2_total", p2_total, e2);
    tick();
    check("commit_idle", {busy, commit_ack, commit_err, sweep_done}, 0);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) tbl[i] = 8'd0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_flags", {busy, sweep_done, commit_ack, commit_err, game_over}, 0);
    check("rst_best_cat", best_cat, 4'hF);
    check("rst_best_score", best_score, 0);
    check("rst_cat_sel", cat_sel, 0);
    check("rst_totals", {p1_total, p2_total}, 0);
    reset_n = 1'b1;

    // Dice 5,5,5,5,5
    tbl[4] = 8'd25; tbl[6] = 8'd25; tbl[7] = 8'd25; tbl[11] = 8'd50;
    do_sweep(1'b0, 4'd11, 8'd50, 1'b1);
    check("dropped_commit_total", p1_total, 0);
    do_commit(1'b0, 4'd11, 1'b0, 1'b1, 9'd50, 9'd0);
    do_commit(1'b0, 4'd11, 1'b0, 1'b0, 9'd50, 9'd0);
    do_commit(1'b1, 4'd12, 1'b0, 1'b0, 9'd50, 9'd0);

    // Upper section: P1 reaches 63 (bonus), P2 reaches 62 (no bonus)
    tbl[0] = 8'd3; tbl[1] = 8'd6; tbl[2] = 8'd9;
    tbl[3] = 8'd12; tbl[4] = 8'd15; tbl[5] = 8'd18;
    do_commit(1'b0, 4'd0, 1'b0, 1'b1, 9'd53, 9'd0);
    do_commit(1'b0, 4'd1, 1'b0, 1'b1, 9'd59, 9'd0);
    do_commit(1'b0, 4'd2, 1'b0, 1'b1, 9'd68, 9'd0);
    do_commit(1'b0, 4'd3, 1'b0, 1'b1, 9'd80, 9'd0);
    do_commit(1'b0, 4'd4, 1'b0, 1'b1, 9'd95, 9'd0);
    do_commit(1'b0, 4'd5, 1'b0, 1'b1, 9'd148, 9'd0);
    tbl[5] = 8'd17;
    do_commit(1'b1, 4'd0, 1'b0, 1'b1, 9'd148, 9'd3);
    do_commit(1'b1, 4'd1, 1'b0, 1'b1, 9'd148, 9'd9);
    do_commit(1'b1, 4'd2, 1'b0, 1'b1, 9'd148, 9'd18);
    do_commit(1'b1, 4'd3, 1'b0, 1'b1, 9'd148, 9'd30);
    do_commit(1'b1, 4'd4, 1'b0, 1'b1, 9'd148, 9'd45);
    do_commit(1'b1, 4'd5, 1'b0, 1'b1, 9'd148, 9'd62);

    // Dice 1,2,3,4,5
    for (int i = 0; i < 16; i++) tbl[i] = 8'd0;
    tbl[0] = 8'd1; tbl[1] = 8'd2; tbl[2] = 8'd3; tbl[3] = 8'd4; tbl[4] = 8'd5;
    tbl[9] = 8'd30; tbl[10] = 8'd40;
    do_sweep(1'b1, 4'd10, 8'd40, 1'b0);
    do_commit(1'b1, 4'd10, 1'b0, 1'b1, 9'd148, 9'd102);
    do_sweep(1'b1, 4'd9, 8'd30, 1'b0);

    // Commit wins over a simultaneous sweep; best result holds
    do_commit(1'b1, 4'd9, 1'b1, 1'b1, 9'd148, 9'd132);
    check("best_hold_cat", best_cat, 4'd9);
    check("best_hold_score", best_score, 8'd30);

    // Reset in cycle 5 of a sweep
    sweep_start = 1'b1;
    player      = 1'b0;
    tick();
    sweep_start = 1'b0;
    repeat (4) tick();
    check("mid_sweep_sel", cat_sel, 4'd4);
    reset_n = 1'b0;
    #1;
    check("abort_flags", {busy, sweep_done, commit_ack, commit_err, game_over}, 0);
    check("abort_best_cat", best_cat, 4'hF);
    check("abort_best_score", best_score, 0);
    check("abort_totals", {p1_total, p2_total}, 0);
    check("abort_cat_sel", cat_sel, 0);
    tick();
    check("abort_no_done", {busy, sweep_done}, 0);
    tick();
    reset_n = 1'b1;

    // Fill both sheets, first commit on the first edge after reset release
    for (int i = 0; i < 16; i++) tbl[i] = (i < 12) ? 8'(i + 1) : 8'd0;
    for (int c = 0; c < 12; c++) begin
      do_commit(1'b0, 4'(c), 1'b0, 1'b1, 9'((c + 1) * (c + 2) / 2), 9'd0);
    end
    for (int c = 0; c < 12; c++) begin
      do_commit(1'b1, 4'(c), 1'b0, 1'b1, 9'd78, 9'((c + 1) * (c + 2) / 2));
      check("game_over", game_over, (c == 11) ? 1 : 0);
    end
    do_sweep(1'b0, 4'hF, 8'd0, 1'b0);
    do_sweep(1'b1, 4'hF, 8'd0, 1'b0);
    do_commit(1'b0, 4'd3, 1'b0, 1'b0, 9'd78, 9'd78);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
